multicycle_control: RTL

//  Multicycle control FSM for the LEGv8 datapath. It sequences fetch, decode, execute, memory and

---
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/write-back over one shared ALU and memory port.
// Latency with zero wait states: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3 cycles. Outputs are Moore-decoded except the ready-gated fetch enables and CBZ PCWrite.
// Backpressure: FETCH, MEMRD and MEMWR hold while iMemReady is low. More than MEM_TIMEOUT idle cycles in one of them traps.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [10:0]      iOpcode,
  input  logic             iZero,
  input  logic             iMemReady,
  output logic             oPCWrite,
  output logic             oIRWrite,
  output logic             oIorD,
  output logic             oReg2Loc,
  output logic [1:0]       oALUSrc,
  output logic [1:0]       oALUOp,
  output logic [1:0]       oMemtoReg,
  output logic [1:0]       oOrigemPC,
  output logic             oRegWrite,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic [3:0]       oState,
  output logic             oIllegal,
  output logic [CNT_W-1:0] oInstrCount
);

  localparam logic [3:0] stateRst     = 4'd0;
  localparam logic [3:0] stateFetch   = 4'd1;
  localparam logic [3:0] stateDecode  = 4'd2;
  localparam logic [3:0] stateExecR   = 4'd3;
  localparam logic [3:0] stateWbR     = 4'd4;
  localparam logic [3:0] stateMemAddr = 4'd5;
  localparam logic [3:0] stateMemRd   = 4'd6;
  localparam logic [3:0] stateWbMem   = 4'd7;
  localparam logic [3:0] stateMemWr   = 4'd8;
  localparam logic [3:0] stateCbz     = 4'd9;
  localparam logic [3:0] stateBranch  = 4'd10;
  localparam logic [3:0] stateTrap    = 4'd15;

  localparam logic [10:0] opLdur = 11'b11111000010;
  localparam logic [10:0] opStur = 11'b11111000000;

  // Wide enough to hold MEM_TIMEOUT itself; the counter never goes past it.
  localparam int timeoutW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [3:0]          state;
  logic [3:0]          nextState;
  logic [timeoutW-1:0] timeoutCnt;
  logic [CNT_W-1:0]    instrCount;
  logic                memWait;
  logic                timedOut;
  logic                retire;

  // Only these three states talk to memory and can stall on the ready handshake.
  assign memWait  = (state == stateFetch) || (state == stateMemRd) || (state == stateMemWr);
  // Ready in the final allowed cycle still wins over the trap.
  assign timedOut = memWait && !iMemReady && (timeoutCnt >= timeoutW'(MEM_TIMEOUT));
  // Every instruction retires on the edge that leaves its last state toward FETCH.
  assign retire   = (state == stateWbR) || (state == stateWbMem) || (state == stateCbz) ||
                    (state == stateBranch) || ((state == stateMemWr) && iMemReady);

  // Next-state selection, including opcode dispatch in DECODE and LDUR/STUR split in MEMADDR.
  always_comb begin
    nextState = state;
    case (state)
      stateRst:     nextState = stateFetch;
      stateFetch: begin
        if (iMemReady)     nextState = stateDecode;
        else if (timedOut) nextState = stateTrap;
      end
      stateDecode: begin
        casez (iOpcode)
          11'b10001011000,
          11'b11001011000,
          11'b10001010000,
          11'b10101010000: nextState = stateExecR;
          11'b11111000010,
          11'b11111000000: nextState = stateMemAddr;
          11'b10110100???: nextState = stateCbz;
          11'b000101?????: nextState = stateBranch;
          default:         nextState = stateTrap;
        endcase
      end
      stateExecR:   nextState = stateWbR;
      stateWbR:     nextState = stateFetch;
      stateMemAddr: begin
        if (iOpcode == opLdur)      nextState = stateMemRd;
        else if (iOpcode == opStur) nextState = stateMemWr;
        else                        nextState = stateTrap;
      end
      stateMemRd: begin
        if (iMemReady)     nextState = stateWbMem;
        else if (timedOut) nextState = stateTrap;
      end
      stateWbMem:   nextState = stateFetch;
      stateMemWr: begin
        if (iMemReady)     nextState = stateFetch;
        else if (timedOut) nextState = stateTrap;
      end
      stateCbz:     nextState = stateFetch;
      stateBranch:  nextState = stateFetch;
      stateTrap:    nextState = stateTrap;
      default:      nextState = stateTrap;
    endcase
  end

  // State register; an asserted reset aborts whatever instruction is in flight.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= stateRst;
    else       state <= nextState;
  end

  // Wait-cycle counter: counts stalled cycles, and is zero on entry to any memory state.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)                               timeoutCnt <= '0;
    else if (memWait && !iMemReady && !timedOut) timeoutCnt <= timeoutCnt + timeoutW'(1);
    else                                     timeoutCnt <= '0;
  end

  // Retired-instruction counter, free-running modulo 2^CNT_W.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)       instrCount <= '0;
    else if (retire) instrCount <= instrCount + CNT_W'(1);
  end

  // Datapath control decode from the current state.
  always_comb begin
    oPCWrite  = 1'b0;
    oIRWrite  = 1'b0;
    oIorD     = 1'b0;
    oReg2Loc  = 1'b0;
    oALUSrc   = 2'b00;
    oALUOp    = 2'b00;
    oMemtoReg = 2'b00;
    oOrigemPC = 2'b00;
    oRegWrite = 1'b0;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    case (state)
      stateFetch: begin
        oMemRead = 1'b1;
        oALUSrc  = 2'b10;
        // PC+4 and the IR load only commit once the instruction word arrives.
        oIRWrite = iMemReady;
        oPCWrite = iMemReady;
      end
      stateDecode:  oALUSrc = 2'b11;
      stateExecR:   oALUOp  = 2'b10;
      stateWbR:     oRegWrite = 1'b1;
      stateMemAddr: oALUSrc = 2'b01;
      stateMemRd: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
      end
      stateWbMem: begin
        oRegWrite = 1'b1;
        oMemtoReg = 2'b01;
      end
      stateMemWr: begin
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
        oReg2Loc  = 1'b1;
      end
      stateCbz: begin
        oReg2Loc  = 1'b1;
        oALUOp    = 2'b01;
        oOrigemPC = 2'b01;
        oPCWrite  = iZero;
      end
      stateBranch: begin
        oPCWrite  = 1'b1;
        oOrigemPC = 2'b10;
      end
      default: ;
    endcase
  end

  assign oState      = state;
  assign oIllegal    = (state == stateTrap);
  assign oInstrCount = instrCount;

endmodule
